// File: rtl/gp1_display_ctrl.sv
// rtl/gp1_display_ctrl.sv - GP1 display-control decode with vblank-committed shadow registers
module gp1_display_ctrl #(
  parameter logic [11:0] RANGE_X0_RST       = 12'h200,
  parameter logic [11:0] RANGE_X1_RST       = 12'hC00,
  parameter logic [9:0]  RANGE_Y0_RST       = 10'h010,
  parameter logic [9:0]  RANGE_Y1_RST       = 10'h100,
  parameter bit          IMMEDIATE_WHEN_OFF = 1'b1
) (
  input  logic        i_gpuPixClk,
  input  logic        i_rst,
  input  logic        i_cmdValid,
  input  logic [31:0] i_cmdData,
  output logic        o_cmdReady,
  input  logic        i_vbl,
  output logic        o_PAL,
  output logic        o_IsInterlace,
  output logic        o_HorizResolution368,
  output logic [1:0]  o_HorizResolution,
  output logic        o_verticalRes480,
  output logic        o_colorDepth24,
  output logic [11:0] o_RangeX0,
  output logic [11:0] o_RangeX1,
  output logic [9:0]  o_RangeY0,
  output logic [9:0]  o_RangeY1,
  output logic [9:0]  o_dispAreaX,
  output logic [8:0]  o_dispAreaY,
  output logic        o_displayDisabled,
  output logic        o_pending
);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_PENDING = 1'b1;

  logic [7:0]  r_mode,  r_shMode;
  logic [11:0] r_x0,    r_shX0;
  logic [11:0] r_x1,    r_shX1;
  logic [9:0]  r_y0,    r_shY0;
  logic [9:0]  r_y1,    r_shY1;
  logic [9:0]  r_areaX, r_shAreaX;
  logic [8:0]  r_areaY, r_shAreaY;
  logic        r_dispDisabled;
  logic [0:0]  r_state;
  logic        r_vblD;

  logic       w_accept;
  logic [5:0] w_op;
  logic       w_softRst;
  logic       w_stage;
  logic       w_vblRise;
  logic       w_commit;
  logic       w_unused_bits;

  assign o_cmdReady = ~i_rst;
  assign w_accept   = i_cmdValid & o_cmdReady;
  assign w_op       = i_cmdData[29:24];
  assign w_softRst  = w_accept & (w_op == 6'h00);
  assign w_stage    = w_accept & ((w_op == 6'h05) | (w_op == 6'h06) |
                                  (w_op == 6'h07) | (w_op == 6'h08));
  assign w_vblRise  = i_vbl & ~r_vblD;
  // Only a pending frame commits; with nothing staged the shadows already match.
  assign w_commit   = (r_state == S_PENDING) &
                      (w_vblRise | (r_dispDisabled & IMMEDIATE_WHEN_OFF));
  assign w_unused_bits = ^{i_cmdData[31:30], r_mode[7]};

  // Delayed vblank for rising-edge detection
  always_ff @(posedge i_gpuPixClk or posedge i_rst) begin
    if (i_rst) r_vblD <= 1'b0;
    else       r_vblD <= i_vbl;
  end

  // Commit FSM: a staged write wins over a same-cycle commit so the new value is not lost
  always_ff @(posedge i_gpuPixClk or posedge i_rst) begin
    if (i_rst)          r_state <= S_IDLE;
    else if (w_softRst) r_state <= S_IDLE;
    else if (w_stage)   r_state <= S_PENDING;
    else if (w_commit)  r_state <= S_IDLE;
  end

  // Shadow registers capture staged GP1 writes; the last write before commit wins
  always_ff @(posedge i_gpuPixClk or posedge i_rst) begin
    if (i_rst || w_softRst) begin
      r_shMode  <= 8'h00;
      r_shX0    <= RANGE_X0_RST;
      r_shX1    <= RANGE_X1_RST;
      r_shY0    <= RANGE_Y0_RST;
      r_shY1    <= RANGE_Y1_RST;
      r_shAreaX <= 10'd0;
      r_shAreaY <= 9'd0;
    end else if (w_accept) begin
      case (w_op)
        6'h05: begin
          r_shAreaX <= i_cmdData[9:0];
          r_shAreaY <= i_cmdData[18:10];
        end
        6'h06: begin
          r_shX0 <= i_cmdData[11:0];
          r_shX1 <= i_cmdData[23:12];
        end
        6'h07: begin
          r_shY0 <= i_cmdData[9:0];
          r_shY1 <= i_cmdData[19:10];
        end
        6'h08:   r_shMode <= i_cmdData[7:0];
        default: ;
      endcase
    end
  end

  // Committed registers: copy the pre-write shadow on commit, soft reset takes priority
  always_ff @(posedge i_gpuPixClk or posedge i_rst) begin
    if (i_rst || w_softRst) begin
      r_mode  <= 8'h00;
      r_x0    <= RANGE_X0_RST;
      r_x1    <= RANGE_X1_RST;
      r_y0    <= RANGE_Y0_RST;
      r_y1    <= RANGE_Y1_RST;
      r_areaX <= 10'd0;
      r_areaY <= 9'd0;
    end else if (w_commit) begin
      r_mode  <= r_shMode;
      r_x0    <= r_shX0;
      r_x1    <= r_shX1;
      r_y0    <= r_shY0;
      r_y1    <= r_shY1;
      r_areaX <= r_shAreaX;
      r_areaY <= r_shAreaY;
    end
  end

  // Display enable is not geometry, so it bypasses the shadow path
  always_ff @(posedge i_gpuPixClk or posedge i_rst) begin
    if (i_rst || w_softRst)                  r_dispDisabled <= 1'b1;
    else if (w_accept && (w_op == 6'h03))    r_dispDisabled <= i_cmdData[0];
  end

  assign o_HorizResolution    = r_mode[1:0];
  assign o_verticalRes480     = r_mode[2];
  assign o_PAL                = r_mode[3];
  assign o_colorDepth24       = r_mode[4];
  assign o_IsInterlace        = r_mode[5];
  assign o_HorizResolution368 = r_mode[6];
  assign o_RangeX0            = r_x0;
  assign o_RangeX1            = r_x1;
  assign o_RangeY0            = r_y0;
  assign o_RangeY1            = r_y1;
  assign o_dispAreaX          = r_areaX;
  assign o_dispAreaY          = r_areaY;
  assign o_displayDisabled    = r_dispDisabled;
  assign o_pending            = r_state;

endmodule

// File: doc/gp1_display_ctrl.md
Name: gp1_display_ctrl

Overview:
- Decodes GP1 display-control commands (00h, 03h, 05h–08h) from the CPU-side command port.
- Holds the display configuration registers that drive the video timing generator and the scanout fetch logic: PAL, interlace, horizontal resolution, display ranges, display-area start and display enable.
- Timing-affecting values are staged in shadow registers and committed at the next vertical-blank start, so the raster never changes geometry mid-frame.
- Sits between the GPU register bus and the video timing block, in the pixel-clock domain.

Parameters:
- RANGE_X0_RST, 12'h200, reset value of horizontal display start.
- RANGE_X1_RST, 12'hC00, reset value of horizontal display end.
- RANGE_Y0_RST, 10'h010, reset value of vertical display start.
- RANGE_Y1_RST, 10'h100, reset value of vertical display end.
- IMMEDIATE_WHEN_OFF, 1, 1 = staged writes commit immediately while display is disabled.

Ports:
- i_gpuPixClk  in  1  video/GPU pixel clock
- i_rst  in  1  asynchronous active-high reset
- i_cmdValid  in  1  GP1 write strobe
- i_cmdData  in  32  GP1 word; opcode = [29:24]
- o_cmdReady  out  1  command accepted when valid&ready
- i_vbl  in  1  vertical blank from timing generator
- o_PAL  out  1  committed mode bit 3
- o_IsInterlace  out  1  committed mode bit 5
- o_HorizResolution368  out  1  committed mode bit 6
- o_HorizResolution  out  2  committed mode bits 1:0
- o_verticalRes480  out  1  committed mode bit 2
- o_colorDepth24  out  1  committed mode bit 4
- o_RangeX0 / o_RangeX1  out  12  committed horizontal range
- o_RangeY0 / o_RangeY1  out  10  committed vertical range
- o_dispAreaX  out  10  committed VRAM display start X
- o_dispAreaY  out  9  committed VRAM display start Y
- o_displayDisabled  out  1  display off
- o_pending  out  1  staged values awaiting commit

Behaviour:
- Reset (async, i_rst=1): all mode bits 0; ranges = RANGE_*_RST; area 0,0; o_displayDisabled=1; o_pending=0; shadows equal committed; vbl edge register=0; o_cmdReady=0 while in reset, 1 otherwise.
- Command decode on valid&ready; effects are registered, visible the next cycle.
- 00h: full soft reset to the reset values above, committed immediately; clears pending. Takes priority over a simultaneous commit.
- 03h: o_displayDisabled <= data[0], immediate, not staged.
- 05h: shadow area X <= [9:0], shadow area Y <= [18:10]; sets pending.
- 06h: shadow X0 <= [11:0], shadow X1 <= [23:12]; sets pending.
- 07h: shadow Y0 <= [9:0], shadow Y1 <= [19:10]; sets pending.
- 08h: shadow mode <= [7:0]; sets pending. Bit 7 (reverse) is stored and not exported.
- Other opcodes (01h, 02h, 04h, 09h–3Fh): accepted, no effect.
- Repeated staged writes before commit overwrite the shadow; the last write wins.
- Commit FSM states:
  - IDLE: pending=0.
  - PENDING: pending=1; goes to IDLE on commit or 00h.
- Commit event = i_vbl rising edge (i_vbl=1 and registered i_vbl=0). It also fires in any cycle while pending and o_displayDisabled=1 and IMMEDIATE_WHEN_OFF=1.
- On commit, all shadows are copied to committed outputs on the next edge, and pending clears.
- Staged write in the same cycle as a commit event:
  - The commit copies the pre-write shadow.
  - The new value lands in the shadow, and pending stays 1 (committed next vblank).
- i_vbl held high at reset release does not generate a commit; a 0→1 transition is required.
- Field boundaries in interlace are not special-cased: commit occurs at every vblank start.

Test Plan:
- Reset release → o_RangeX0=200h, X1=C00h, Y0=10h, Y1=100h, o_displayDisabled=1, o_pending=0, o_cmdReady=1.
- 03h data 0 → o_displayDisabled=0 next cycle. Then 08h data 0000_0009h with i_vbl=0 → o_pending=1 and o_PAL=0 unchanged. Pulse i_vbl 0→1 → next cycle o_PAL=1, o_HorizResolution=01b, o_pending=0.
- Display enabled; 06h with X0=260h, X1=C60h, then 06h with X0=300h, X1=D00h before vblank → after vbl edge o_RangeX0=300h, o_RangeX1=D00h.
- Display enabled; 07h (Y0=20h) written in the same cycle as the vbl rising edge → committed Y0 stays 10h and o_pending=1. On the next vbl edge, Y0=20h.
- Display disabled (IMMEDIATE_WHEN_OFF=1); 05h with X=100, Y=256 → o_dispAreaX=100, o_dispAreaY=256 within 2 cycles, no vbl needed.
- Pending 08h then 00h, and async i_rst mid-pending → defaults restored, o_pending=0, no stale commit on the following vbl edge.
